regfile_sb_param: RTL and testbench

// Parametrised 2-read/1-write integer register file for the RISC-V core, with
// a per-register pending scoreboard. Sits between decode (reads, issue) and

---
 rtl/regfile_sb_param.sv | 104 ++++++++++
 tb/tb_regfile_sb_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb_param.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_param
// Description : 2-read/1-write register file with a per-entry pending
//               scoreboard, write-to-read bypass and sequenced clearing.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_done,
  input  logic            rg_wrt_en,
  input  logic [AW-1:0]   rg_wrt_addr,
  input  logic [XLEN-1:0] rg_wrt_data,
  input  logic [AW-1:0]   rg_rd_addr1,
  output logic [XLEN-1:0] rg_rd_data1,
  input  logic [AW-1:0]   rg_rd_addr2,
  output logic [XLEN-1:0] rg_rd_data2,
  input  logic            sb_set_en,
  input  logic [AW-1:0]   sb_set_addr,
  output logic            rd1_pending,
  output logic            rd2_pending
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] entries [NREGS];
  logic [NREGS-1:0] sb;

  logic ready;
  logic wr_ok;
  logic set_ok;

  assign ready     = (state == ST_READY);
  assign init_done = ready;
  assign wr_ok     = ready && rg_wrt_en && !(ZERO_REG && (rg_wrt_addr == '0));
  assign set_ok    = ready && sb_set_en && !(ZERO_REG && (sb_set_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      sb      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(NREGS - 1)) state <= ST_READY;
        end
        default: begin
          // A new issue owns the register even if writeback retires it now.
          for (int i = 0; i < NREGS; i++) begin
            if (set_ok && (sb_set_addr == AW'(i)))
              sb[i] <= 1'b1;
            else if (wr_ok && (rg_wrt_addr == AW'(i)))
              sb[i] <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage carries no reset; the INIT sequence clears one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT)
        entries[clr_cnt] <= '0;
      else if (wr_ok)
        entries[rg_wrt_addr] <= rg_wrt_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = entries[addr];
    if (!ready || (ZERO_REG && (addr == '0)))
      val = '0;
    else if (wr_ok && (rg_wrt_addr == addr))
      val = rg_wrt_data;
    return val;
  endfunction

  // Pending drops in the same cycle the bypass starts supplying fresh data.
  function automatic logic pend_port(input logic [AW-1:0] addr);
    return ready && sb[addr] && !(wr_ok && (rg_wrt_addr == addr));
  endfunction

  assign rg_rd_data1 = read_port(rg_rd_addr1);
  assign rg_rd_data2 = read_port(rg_rd_addr2);
  assign rd1_pending = pend_port(rg_rd_addr1);
  assign rd2_pending = pend_port(rg_rd_addr2);

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb_param
// Description : Randomized self-checking bench for regfile_sb_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default-parameter instance
  logic        reset = 1'b0, init_done;
  logic        wr_en = 1'b0, set_en = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0, set_addr = '0;
  logic [31:0] wr_data = '0, rd_data1, rd_data2;
  logic        pend1, pend2;

  regfile_sb_param dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .rg_wrt_en(wr_en), .rg_wrt_addr(wr_addr), .rg_wrt_data(wr_data),
    .rg_rd_addr1(rd_addr1), .rg_rd_data1(rd_data1),
    .rg_rd_addr2(rd_addr2), .rg_rd_data2(rd_data2),
    .sb_set_en(set_en), .sb_set_addr(set_addr),
    .rd1_pending(pend1), .rd2_pending(pend2)
  );

  // XLEN=64, NREGS=16 instance
  logic        b_reset = 1'b0, b_done;
  logic        b_wr_en = 1'b0, b_set_en = 1'b0;
  logic [3:0]  b_wr_addr = '0, b_rd1 = '0, b_rd2 = '0, b_set_addr = '0;
  logic [63:0] b_wr_data = '0, b_data1, b_data2;
  logic        b_pend1, b_pend2;

  regfile_sb_param #(.XLEN(64), .NREGS(16)) dut_b (
    .clk(clk), .reset(b_reset), .init_done(b_done),
    .rg_wrt_en(b_wr_en), .rg_wrt_addr(b_wr_addr), .rg_wrt_data(b_wr_data),
    .rg_rd_addr1(b_rd1), .rg_rd_data1(b_data1),
    .rg_rd_addr2(b_rd2), .rg_rd_data2(b_data2),
    .sb_set_en(b_set_en), .sb_set_addr(b_set_addr),
    .rd1_pending(b_pend1), .rd2_pending(b_pend2)
  );

  // Reference model: architectural contents, pending set, cycles left in INIT
  logic [31:0] m_regs [32];
  bit          m_sb   [32];
  int          m_left = 32;

  function automatic bit m_ready();
    return m_left == 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_ready() || a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_pend(input logic [4:0] a);
    if (!m_ready() || a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_sb[a];
  endfunction

  task automatic step();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_sb[i] = 0; end
      m_left = 32;
    end else if (m_left != 0) begin
      m_left--;
    end else begin
      if (wr_en && wr_addr != 0) begin m_regs[wr_addr] = wr_data; m_sb[wr_addr] = 0; end
      if (set_en && set_addr != 0) m_sb[set_addr] = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; set_en = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; set_en = 1'b0;
    step();
    reset = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      if (c != 0) step();
      rd_addr1 = 5'($urandom_range(0, 31)); #1;
      tests++;
      if (init_done !== (c == 32)) begin
        fails++; $display("FAIL reset_init_done c=%0d: got %b expected %b", c, init_done, (c == 32));
      end
      tests++;
      if (rd_data1 !== 32'h0) begin
        fails++; $display("FAIL reset_read c=%0d: got %h expected 0", c, rd_data1);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      wr_en = (c == 5); wr_addr = 5'd5; wr_data = 32'hCAFE_F00D;
      step();
    end
    wr_en = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 3) begin wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_2222; end
      else wr_en = 1'b0;
      step();
      tests++;
      if (init_done !== (c == 32)) begin
        fails++; $display("FAIL midreset_init_done c=%0d: got %b expected %b", c, init_done, (c == 32));
      end
    end
    wr_en = 1'b0; rd_addr1 = 5'd5; #1;
    tests++;
    if (rd_data1 !== 32'h0) begin
      fails++; $display("FAIL init_write_dropped: got %h expected 0", rd_data1);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd7; #1;
    tests++;
    if (rd_data1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data1);
    end
    step(); wr_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; tests++;
      if (rd_data1 !== 32'hDEADBEEF) begin
        fails++; $display("FAIL bypass_later c=%0d: got %h expected deadbeef", c, rd_data1);
      end
      step();
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_en = 1'b1; set_addr = 5'd0; rd_addr1 = 5'd0; #1;
    tests++;
    if (rd_data1 !== 32'h0) begin
      fails++; $display("FAIL zero_bypass: got %h expected 0", rd_data1);
    end
    step(); idle(); #1;
    tests++;
    if (rd_data1 !== 32'h0 || pend1 !== 1'b0) begin
      fails++; $display("FAIL zero_after: got data %h pend %b expected 0 0", rd_data1, pend1);
    end
  endtask

  task automatic test_scoreboard();
    set_en = 1'b1; set_addr = 5'd3; rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    step(); set_en = 1'b0; #1;
    tests++;
    if (pend1 !== 1'b1 || pend2 !== 1'b1) begin
      fails++; $display("FAIL sb_set: got %b%b expected 11", pend1, pend2);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; #1;
    tests++;
    if (pend1 !== 1'b0 || rd_data1 !== 32'h55) begin
      fails++; $display("FAIL sb_clear_same_cycle: got pend %b data %h expected 0 55", pend1, rd_data1);
    end
    step(); wr_en = 1'b0; #1;
    tests++;
    if (pend1 !== 1'b0 || rd_data1 !== 32'h55) begin
      fails++; $display("FAIL sb_clear_after: got pend %b data %h expected 0 55", pend1, rd_data1);
    end
    set_en = 1'b1; set_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
    step(); idle(); #1;
    tests++;
    if (pend1 !== 1'b1 || rd_data1 !== 32'h66) begin
      fails++; $display("FAIL sb_set_wins: got pend %b data %h expected 1 66", pend1, rd_data1);
    end
    wr_en = 1'b1; wr_data = 32'h77; step(); idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 99) < 50);
      wr_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_data  = $urandom;
      set_en   = ($urandom_range(0, 99) < 40);
      set_addr = 5'($urandom_range(0, 7));
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom);
      #1;
      tests++;
      if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2)) begin
        fails++;
        $display("FAIL rand_data c=%0d: got %h/%h expected %h/%h", c, rd_data1, rd_data2,
                 exp_rd(rd_addr1), exp_rd(rd_addr2));
      end
      tests++;
      if (pend1 !== exp_pend(rd_addr1) || pend2 !== exp_pend(rd_addr2)) begin
        fails++;
        $display("FAIL rand_pend c=%0d: got %b/%b expected %b/%b", c, pend1, pend2,
                 exp_pend(rd_addr1), exp_pend(rd_addr2));
      end
      step();
    end
    idle();
  endtask

  task automatic test_param();
    b_reset = 1'b1; @(posedge clk); #1; b_reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      b_rd1 = 4'd15; @(posedge clk); #1;
      tests++;
      if (b_done !== (c == 16)) begin
        fails++; $display("FAIL param_init_done c=%0d: got %b expected %b", c, b_done, (c == 16));
      end
    end
    tests++;
    if (b_data1 !== 64'h0) begin
      fails++; $display("FAIL param_cleared: got %h expected 0", b_data1);
    end
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'hFFFF_0000_FFFF_0000;
    b_rd1 = 4'd15; b_rd2 = 4'd14; #1;
    tests++;
    if (b_data1 !== 64'hFFFF_0000_FFFF_0000 || b_data2 !== 64'h0) begin
      fails++; $display("FAIL param_bypass: got %h/%h expected ffff0000ffff0000/0", b_data1, b_data2);
    end
    @(posedge clk); #1; b_wr_en = 1'b0; #1;
    tests++;
    if (b_data1 !== 64'hFFFF_0000_FFFF_0000) begin
      fails++; $display("FAIL param_readback: got %h expected ffff0000ffff0000", b_data1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_reset_mid_init();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
